// File: rtl/mem_wb_regfile.sv
// MEM/WB pipeline register, 32x32 register file commit, and two decode read ports with WB bypass.
// Latency: MEM result on wb_* next cycle (bypass visible then); resident in the array one cycle later.
// Backpressure: stall_i[4] alone inserts a bubble, stall_i[5:4]=11 holds WB and blocks the array write.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   stall_i[5:0]        pipeline stall vector (bit 4 = MEM stalled, bit 5 = WB stalled)
//   flush_i             kills the MEM/WB register contents
//   mem_waddr/we/wdata  result from the memory stage
//   wb_waddr/we/wdata   latched MEM/WB register, also drives the array write
//   re1/raddr1/rdata1   decode read port 1 (combinational)
//   re2/raddr2/rdata2   decode read port 2 (combinational)
module mem_wb_regfile #(
    parameter int REG_NUM = 32,
    parameter int REG_AW  = 5,
    parameter int DW      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall_i,
    input  logic              flush_i,
    input  logic [REG_AW-1:0] mem_waddr_i,
    input  logic              mem_we_i,
    input  logic [DW-1:0]     mem_wdata_i,
    output logic [REG_AW-1:0] wb_waddr_o,
    output logic              wb_we_o,
    output logic [DW-1:0]     wb_wdata_o,
    input  logic              re1_i,
    input  logic [REG_AW-1:0] raddr1_i,
    output logic [DW-1:0]     rdata1_o,
    input  logic              re2_i,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [DW-1:0]     rdata2_o
);

    // ------------------------------------------------------------------
    // MEM/WB pipeline register
    // ------------------------------------------------------------------
    logic [REG_AW-1:0] wb_waddr_q, wb_waddr_d;
    logic              wb_we_q,    wb_we_d;
    logic [DW-1:0]     wb_wdata_q, wb_wdata_d;

    logic mem_stall;
    logic wb_stall;
    logic stall_unused;

    assign mem_stall    = stall_i[4];
    assign wb_stall     = stall_i[5];
    // Earlier-stage stall bits belong to other pipeline stages.
    assign stall_unused = ^stall_i[3:0];

    always_comb begin
        wb_waddr_d = wb_waddr_q;
        wb_we_d    = wb_we_q;
        wb_wdata_d = wb_wdata_q;
        if (flush_i) begin
            wb_waddr_d = '0;
            wb_we_d    = 1'b0;
            wb_wdata_d = '0;
        end else if (mem_stall && !wb_stall) begin
            // MEM is frozen but WB drains: the MEM result stays put for
            // a later cycle, so advancing it now would commit it twice.
            wb_waddr_d = '0;
            wb_we_d    = 1'b0;
            wb_wdata_d = '0;
        end else if (!mem_stall) begin
            wb_waddr_d = mem_waddr_i;
            wb_we_d    = mem_we_i;
            wb_wdata_d = mem_wdata_i;
        end
        // mem_stall && wb_stall: hold current contents (defaults)
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_waddr_q <= '0;
            wb_we_q    <= 1'b0;
            wb_wdata_q <= '0;
        end else begin
            wb_waddr_q <= wb_waddr_d;
            wb_we_q    <= wb_we_d;
            wb_wdata_q <= wb_wdata_d;
        end
    end

    assign wb_waddr_o = wb_waddr_q;
    assign wb_we_o    = wb_we_q;
    assign wb_wdata_o = wb_wdata_q;

    // ------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------
    logic [DW-1:0] rf_q [REG_NUM];
    logic          rf_wr;

    // The commit uses the pre-edge latched values. Flush does not gate it:
    // the instruction in WB is older than the one being flushed. A held WB
    // (stall_i[5]) defers the commit until the stall lifts.
    assign rf_wr = wb_we_q && (wb_waddr_q != '0) && !wb_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_wr) begin
            rf_q[wb_waddr_q] <= wb_wdata_q;
        end
    end

    // ------------------------------------------------------------------
    // Read ports with writeback bypass
    // ------------------------------------------------------------------
    function automatic logic [DW-1:0] read_port(
        input logic              re,
        input logic [REG_AW-1:0] raddr,
        input logic [DW-1:0]     array_val,
        input logic [REG_AW-1:0] byp_addr,
        input logic              byp_we,
        input logic [DW-1:0]     byp_data
    );
        logic [DW-1:0] val;
        val = '0;
        if (!re || raddr == '0) begin
            // r0 reads as zero even when WB targets it
            val = '0;
        end else if (byp_we && raddr == byp_addr) begin
            val = byp_data;
        end else begin
            val = array_val;
        end
        return val;
    endfunction

    always_comb begin
        rdata1_o = read_port(re1_i, raddr1_i, rf_q[raddr1_i],
                             wb_waddr_q, wb_we_q, wb_wdata_q);
        rdata2_o = read_port(re2_i, raddr2_i, rf_q[raddr2_i],
                             wb_waddr_q, wb_we_q, wb_wdata_q);
    end

endmodule

// File: tb/tb_mem_wb_regfile.sv
// Testbench for mem_wb_regfile: directed vector table, reset sequence, and
// randomized traffic compared against a register-file reference model.
module tb_mem_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  stall_i = '0;
    logic        flush_i = 1'b0;
    logic [4:0]  mem_waddr_i = '0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_wdata_i = '0;
    logic [4:0]  wb_waddr_o;
    logic        wb_we_o;
    logic [31:0] wb_wdata_o;
    logic        re1_i = 1'b0;
    logic [4:0]  raddr1_i = '0;
    logic [31:0] rdata1_o;
    logic        re2_i = 1'b0;
    logic [4:0]  raddr2_i = '0;
    logic [31:0] rdata2_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_wb_regfile #(.REG_NUM(32), .REG_AW(5), .DW(32)) dut (
        .clk        (clk),
        .rst        (rst_n),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .mem_waddr_i(mem_waddr_i),
        .mem_we_i   (mem_we_i),
        .mem_wdata_i(mem_wdata_i),
        .wb_waddr_o (wb_waddr_o),
        .wb_we_o    (wb_we_o),
        .wb_wdata_o (wb_wdata_o),
        .re1_i      (re1_i),
        .raddr1_i   (raddr1_i),
        .rdata1_o   (rdata1_o),
        .re2_i      (re2_i),
        .raddr2_i   (raddr2_i),
        .rdata2_o   (rdata2_o)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_rf [32];
    logic [4:0]  m_waddr;
    logic        m_we;
    logic [31:0] m_wdata;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_waddr = '0;
        m_we    = 1'b0;
        m_wdata = '0;
    endtask

    // One rising edge: commit whatever sits in WB (unless WB is held),
    // then decide what WB holds next.
    task automatic model_edge();
        if (m_we && m_waddr != 0 && !stall_i[5]) m_rf[m_waddr] = m_wdata;
        if (flush_i || (stall_i[4] && !stall_i[5])) begin
            m_waddr = 0; m_we = 0; m_wdata = 0;
        end else if (!stall_i[4]) begin
            m_waddr = mem_waddr_i; m_we = mem_we_i; m_wdata = mem_wdata_i;
        end
    endtask

    function automatic logic [31:0] model_read(input logic re, input logic [4:0] a);
        if (!re || a == 0) return 32'h0;
        if (m_we && m_waddr == a) return m_wdata;
        return m_rf[a];
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one edge; inputs were driven after the previous edge.
    task automatic do_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic [5:0] st, input logic fl, input logic [4:0] wa,
                         input logic we, input logic [31:0] wd,
                         input logic r1, input logic [4:0] a1,
                         input logic r2, input logic [4:0] a2);
        stall_i = st; flush_i = fl; mem_waddr_i = wa; mem_we_i = we; mem_wdata_i = wd;
        re1_i = r1; raddr1_i = a1; re2_i = r2; raddr2_i = a2;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [4:0]  waddr;
        logic        we;
        logic [31:0] wdata;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
        logic [31:0] x_rd1;   // read data before the edge
        logic [31:0] x_rd2;
        logic [4:0]  x_waddr; // wb_* after the edge
        logic        x_we;
        logic [31:0] x_wdata;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [5:0] st, input logic fl, input logic [4:0] wa,
                                input logic we, input logic [31:0] wd,
                                input logic r1, input logic [4:0] a1,
                                input logic r2, input logic [4:0] a2,
                                input logic [31:0] x1, input logic [31:0] x2,
                                input logic [4:0] xa, input logic xw, input logic [31:0] xd);
        vec_t v;
        v.stall = st; v.flush = fl; v.waddr = wa; v.we = we; v.wdata = wd;
        v.re1 = r1; v.ra1 = a1; v.re2 = r2; v.ra2 = a2;
        v.x_rd1 = x1; v.x_rd2 = x2; v.x_waddr = xa; v.x_we = xw; v.x_wdata = xd;
        return v;
    endfunction

    initial begin
        logic [5:0] st;
        logic [4:0] a1, a2;
        int         pick;

        // basic writeback / bypass / array
        vecs[0]  = mk(6'b000000, 0, 5, 1, 32'hDEADBEEF, 1, 5, 0, 0, 32'h0,        32'h0,        5, 1, 32'hDEADBEEF);
        vecs[1]  = mk(6'b000000, 0, 0, 0, 32'h0,        1, 5, 0, 0, 32'hDEADBEEF, 32'h0,        0, 0, 32'h0);
        vecs[2]  = mk(6'b000000, 0, 0, 0, 32'h0,        1, 5, 1, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'h0);
        // register 0
        vecs[3]  = mk(6'b000000, 0, 0, 1, 32'h12345678, 1, 0, 1, 0, 32'h0,        32'h0,        0, 1, 32'h12345678);
        vecs[4]  = mk(6'b000000, 0, 0, 0, 32'h0,        1, 0, 1, 0, 32'h0,        32'h0,        0, 0, 32'h0);
        vecs[5]  = mk(6'b000000, 0, 0, 0, 32'h0,        1, 0, 1, 0, 32'h0,        32'h0,        0, 0, 32'h0);
        // MEM-only stall bubble, then hold, then release
        vecs[6]  = mk(6'b010000, 0, 7, 1, 32'h55,       1, 7, 1, 7, 32'h0,        32'h0,        0, 0, 32'h0);
        vecs[7]  = mk(6'b000000, 0, 7, 1, 32'h55,       1, 7, 0, 0, 32'h0,        32'h0,        7, 1, 32'h55);
        vecs[8]  = mk(6'b110000, 0, 8, 1, 32'h99,       1, 7, 1, 8, 32'h55,       32'h0,        7, 1, 32'h55);
        vecs[9]  = mk(6'b110000, 0, 8, 1, 32'h99,       1, 7, 1, 7, 32'h55,       32'h55,       7, 1, 32'h55);
        vecs[10] = mk(6'b000000, 0, 0, 0, 32'h0,        1, 7, 1, 8, 32'h55,       32'h0,        0, 0, 32'h0);
        vecs[11] = mk(6'b000000, 0, 0, 0, 32'h0,        1, 7, 1, 8, 32'h55,       32'h0,        0, 0, 32'h0);
        // flush over WB hold: r3 keeps its old value
        vecs[12] = mk(6'b000000, 0, 3, 1, 32'h33,       1, 3, 0, 0, 32'h0,        32'h0,        3, 1, 32'h33);
        vecs[13] = mk(6'b000000, 0, 3, 1, 32'hAA,       1, 3, 0, 0, 32'h33,       32'h0,        3, 1, 32'hAA);
        vecs[14] = mk(6'b110000, 1, 4, 1, 32'h77,       1, 3, 1, 4, 32'hAA,       32'h0,        0, 0, 32'h0);
        vecs[15] = mk(6'b000000, 0, 0, 0, 32'h0,        1, 3, 1, 4, 32'h33,       32'h0,        0, 0, 32'h0);
        // dual-port same-address, back-to-back writes
        vecs[16] = mk(6'b000000, 0, 9, 1, 32'h1,        1, 9, 0, 0, 32'h0,        32'h0,        9, 1, 32'h1);
        vecs[17] = mk(6'b000000, 0, 9, 1, 32'h2,        1, 9, 1, 9, 32'h1,        32'h1,        9, 1, 32'h2);
        vecs[18] = mk(6'b000000, 0, 0, 0, 32'h0,        1, 9, 1, 9, 32'h2,        32'h2,        0, 0, 32'h0);
        vecs[19] = mk(6'b000000, 0, 0, 0, 32'h0,        1, 9, 0, 9, 32'h2,        32'h0,        0, 0, 32'h0);
        // flush without WB stall: pending write still lands
        vecs[20] = mk(6'b000000, 0, 10, 1, 32'hA5A5,    1, 10, 0, 0, 32'h0,       32'h0,        10, 1, 32'hA5A5);
        vecs[21] = mk(6'b000000, 1, 11, 1, 32'hBB,      1, 10, 1, 11, 32'hA5A5,   32'h0,        0, 0, 32'h0);
        vecs[22] = mk(6'b000000, 0, 0, 0, 32'h0,        1, 10, 1, 11, 32'hA5A5,   32'h0,        0, 0, 32'h0);

        // ---------------- reset ----------------
        model_reset();
        #12;
        chk("reset wb_we", {31'h0, wb_we_o}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // latch r5 into WB, then assert reset mid-cycle before it commits
        drive(6'b0, 0, 5, 1, 32'hCAFE0005, 0, 0, 0, 0);
        do_cycle();
        chk("pre-reset wb_we", {31'h0, wb_we_o}, 32'h1);
        drive(6'b0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async reset wb_waddr", {27'h0, wb_waddr_o}, 32'h0);
        chk("async reset wb_we",    {31'h0, wb_we_o},    32'h0);
        chk("async reset wb_wdata", wb_wdata_o,          32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int r = 1; r < 32; r++) begin
            drive(6'b0, 0, 0, 0, 32'h0, 1, r[4:0], 1, 5'(31 - r + 1));
            #1;
            chk($sformatf("post-reset rd1 r%0d", r), rdata1_o, 32'h0);
        end
        chk("post-reset rd2", rdata2_o, 32'h0);
        @(posedge clk); #1;   // idle edge, keeps model and DUT aligned
        model_edge();

        // ---------------- table ----------------
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].waddr, vecs[i].we, vecs[i].wdata,
                  vecs[i].re1, vecs[i].ra1, vecs[i].re2, vecs[i].ra2);
            @(negedge clk);
            chk($sformatf("vec%0d rdata1", i), rdata1_o, vecs[i].x_rd1);
            chk($sformatf("vec%0d rdata2", i), rdata2_o, vecs[i].x_rd2);
            do_cycle();
            chk($sformatf("vec%0d wb_waddr", i), {27'h0, wb_waddr_o}, {27'h0, vecs[i].x_waddr});
            chk($sformatf("vec%0d wb_we", i),    {31'h0, wb_we_o},    {31'h0, vecs[i].x_we});
            chk($sformatf("vec%0d wb_wdata", i), wb_wdata_o,          vecs[i].x_wdata);
        end

        // ---------------- randomized vs model ----------------
        for (int i = 0; i < 600; i++) begin
            pick = $urandom_range(0, 9);
            st = 6'($urandom_range(0, 15));
            if (pick >= 8)      st[5:4] = 2'b11;
            else if (pick >= 6) st[5:4] = 2'b01;
            else                st[5:4] = 2'b00;
            a1 = 5'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 7));
            drive(st, ($urandom_range(0, 9) == 0), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) != 0), $urandom,
                  ($urandom_range(0, 7) != 0), a1, ($urandom_range(0, 7) != 0), a2);
            @(negedge clk);
            chk($sformatf("rand%0d rdata1", i), rdata1_o, model_read(re1_i, raddr1_i));
            chk($sformatf("rand%0d rdata2", i), rdata2_o, model_read(re2_i, raddr2_i));
            do_cycle();
            chk($sformatf("rand%0d wb_waddr", i), {27'h0, wb_waddr_o}, {27'h0, m_waddr});
            chk($sformatf("rand%0d wb_we", i),    {31'h0, wb_we_o},    {31'h0, m_we});
            chk($sformatf("rand%0d wb_wdata", i), wb_wdata_o,          m_wdata);
        end

        // final sweep of the whole array through an idle pipeline
        drive(6'b0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
        do_cycle();
        do_cycle();
        for (int r = 0; r < 32; r++) begin
            re1_i = 1'b1; raddr1_i = r[4:0];
            #1;
            chk($sformatf("sweep r%0d", r), rdata1_o, model_read(1'b1, r[4:0]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
